// File: rtl/spi_cmd_decoder.sv
// +----------------------------------------------------------------------------+
// | spi_cmd_decoder: SPI byte-stream to register-file access decoder           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_cmd_decoder #(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 7'h1F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  input  logic              cs_n,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_write,
  output logic              reg_read,
  input  logic [7:0]        reg_rdata,
  output logic              addr_err
);

  localparam logic [0:0] S_CMD  = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  logic       r_s1, r_s2, r_s3;
  logic       r_cs1, r_cs2;
  logic [0:0] r_state;
  logic       r_rw;
  logic       r_rd_inv;
  logic       w_byte_evt;
  logic       w_cs_hi;
  logic       w_cmd_ok;
  logic       w_addr_ok;

  assign w_byte_evt = r_s2 & ~r_s3;
  assign w_cs_hi    = r_cs2;
  assign w_cmd_ok   = (data_in[ADDR_W-1:0] <= ADDR_MAX);
  assign w_addr_ok  = (reg_addr <= ADDR_MAX);

  // Both inputs come from the sclk side; cs_n idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_cs1 <= 1'b1;
      r_cs2 <= 1'b1;
    end else begin
      r_s1  <= byte_sync;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_cs1 <= cs_n;
      r_cs2 <= r_cs1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CMD;
      r_rw      <= 1'b0;
      r_rd_inv  <= 1'b0;
      data_out  <= 8'h00;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      r_rd_inv  <= 1'b0;

      // Read data is captured one cycle after the strobe, once reg_addr is settled.
      if (reg_read) begin
        data_out <= reg_rdata;
      end else if (r_rd_inv) begin
        data_out <= 8'h00;
      end

      if (w_byte_evt) begin
        case (r_state)
          S_CMD: begin
            r_rw     <= data_in[7];
            reg_addr <= data_in[ADDR_W-1:0];
            r_state  <= S_DATA;
            if (!data_in[7]) begin
              if (w_cmd_ok) begin
                reg_read <= 1'b1;
              end else begin
                r_rd_inv <= 1'b1;
                addr_err <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_CMD;
            if (r_rw) begin
              if (w_addr_ok) begin
                reg_wdata <= data_in;
                reg_write <= 1'b1;
              end else begin
                addr_err <= 1'b1;
              end
            end
          end
        endcase
      end

      // A byte landing with the frame end is still processed, but the frame restarts.
      if (w_cs_hi) begin
        r_state <= S_CMD;
      end
    end
  end

endmodule

`default_nettype wire
